// File: rtl/vga_pkg.sv
// Shared VGA constants: 800x600 active area, cursor sprite size, pixel codes, colours.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;

   localparam int unsigned CUR_W = 16;
   localparam int unsigned CUR_H = 16;

   // Sprite pixel codes; 2'b11 is reserved and drawn as transparent.
   localparam logic [1:0] PIX_TRANSP = 2'b00;
   localparam logic [1:0] PIX_EDGE   = 2'b01;
   localparam logic [1:0] PIX_FILL   = 2'b10;

   localparam logic [11:0] COLOR_EDGE  = 12'h000;
   localparam logic [11:0] COLOR_FILL  = 12'hFFF;
   localparam logic [11:0] COLOR_PRESS = 12'hF80;

   // Timing bundle carried alongside every pixel.
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } vga_timing_t;

endpackage

// File: rtl/cursor_rom.sv
// 256 x 2-bit synchronous-read ROM holding the 16x16 arrow bitmap, address {row,col}.
module cursor_rom
   import vga_pkg::*;
(
   input  logic       pclk,
   input  logic [7:0] addr,
   output logic [1:0] pix
);

   // Arrow: tip at (0,0), left edge on col 0, diagonal edge on col = row,
   // filled interior, closed by a horizontal edge on row 11.
   function automatic logic [1:0] arrow_pix(input logic [3:0] row, input logic [3:0] col);
      logic [1:0] p;
      p = PIX_TRANSP;
      if (row < 4'd11) begin
         if (col == 4'd0 || col == row) p = PIX_EDGE;
         else if (col < row)            p = PIX_FILL;
      end else if (row == 4'd11) begin
         if (col <= 4'd11)              p = PIX_EDGE;
      end
      return p;
   endfunction

   // Registered read, one cycle latency.
   always_ff @(posedge pclk) begin
      pix <= arrow_pix(addr[7:4], addr[3:0]);
   end

endmodule

// File: rtl/draw_cursor.sv
// Final overlay stage: composites a 16x16 mouse pointer over rgb_in with 2-cycle latency.
module draw_cursor
   import vga_pkg::*;
(
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        mouse_left,
   input  logic        cursor_en,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);

   logic        vblnk_d;
   logic        vblnk_rise;
   logic [11:0] x_l;
   logic [11:0] y_l;
   logic        en_l;

   logic [11:0] h_ext;
   logic [11:0] v_ext;
   logic        hit;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [1:0]  pix;

   vga_timing_t t_in;
   vga_timing_t t_s1;
   logic        hit_s1;
   logic        left_s1;
   logic [11:0] rgb_s1;

   assign vblnk_rise = vblnk_in & ~vblnk_d;

   // Position/enable are sampled once per frame so the pointer never tears.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_d <= 1'b0;
         x_l     <= '0;
         y_l     <= '0;
         en_l    <= 1'b0;
      end else begin
         vblnk_d <= vblnk_in;
         if (vblnk_rise) begin
            x_l  <= (xpos > X_MAX) ? X_MAX : xpos;
            y_l  <= (ypos > Y_MAX) ? Y_MAX : ypos;
            en_l <= cursor_en;
         end
      end
   end

   // 12-bit compare: x_l + CUR_W cannot overflow, so sprites clip at the edge instead of wrapping.
   assign h_ext = {1'b0, hcount_in};
   assign v_ext = {1'b0, vcount_in};
   assign hit   = en_l
                  && (h_ext >= x_l) && (h_ext < x_l + 12'(CUR_W))
                  && (v_ext >= y_l) && (v_ext < y_l + 12'(CUR_H));
   // Low bits of the offset only depend on the low bits of the operands.
   assign col   = h_ext[3:0] - x_l[3:0];
   assign row   = v_ext[3:0] - y_l[3:0];

   assign t_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

   cursor_rom u_cursor_rom (
      .pclk (pclk),
      .addr ({row, col}),
      .pix  (pix)
   );

   // Stage 1: align hit, button, colour and timing with the ROM read.
   always_ff @(posedge pclk) begin
      if (rst) begin
         t_s1    <= '0;
         hit_s1  <= 1'b0;
         left_s1 <= 1'b0;
         rgb_s1  <= '0;
      end else begin
         t_s1    <= t_in;
         hit_s1  <= hit;
         left_s1 <= mouse_left;
         rgb_s1  <= rgb_in;
      end
   end

   // Stage 2: registered outputs; blanking forces black, otherwise overlay opaque sprite codes.
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= t_s1.hcount;
         vcount_out <= t_s1.vcount;
         hsync_out  <= t_s1.hsync;
         vsync_out  <= t_s1.vsync;
         hblnk_out  <= t_s1.hblnk;
         vblnk_out  <= t_s1.vblnk;
         if (t_s1.hblnk || t_s1.vblnk) begin
            rgb_out <= '0;
         end else if (hit_s1 && pix == PIX_EDGE) begin
            rgb_out <= COLOR_EDGE;
         end else if (hit_s1 && pix == PIX_FILL) begin
            rgb_out <= left_s1 ? COLOR_PRESS : COLOR_FILL;
         end else begin
            rgb_out <= rgb_s1;
         end
      end
   end

endmodule

// File: tb/tb_draw_cursor.sv
// Directed bench for draw_cursor: reset, latency, frame latch, sprite colours, clamp and clip.
module tb_draw_cursor;

   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, xpos, ypos;
   logic        mouse_left, cursor_en;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   int n_checks = 0;
   int n_errors = 0;

   draw_cursor dut (
      .pclk       (pclk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .mouse_left (mouse_left),
      .cursor_en  (cursor_en),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Hold one pixel for two edges, then compare the composited colour and delayed hcount.
   task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                        input logic hb, input logic vb, input string tag,
                        input logic [11:0] exp);
      hcount_in = h;
      vcount_in = v;
      rgb_in    = rgb;
      hblnk_in  = hb;
      vblnk_in  = vb;
      tick();
      tick();
      check({tag, " rgb"}, 32'(rgb_out), 32'(exp));
      check({tag, " hcount"}, 32'(hcount_out), 32'(h));
   endtask

   // Produce one vblank rising edge with the given cursor request.
   task automatic latch(input logic [11:0] x, input logic [11:0] y, input logic en);
      xpos      = x;
      ypos      = y;
      cursor_en = en;
      vblnk_in  = 1'b0;
      hblnk_in  = 1'b0;
      tick();
      vblnk_in  = 1'b1;
      hblnk_in  = 1'b1;
      tick();
      tick();
      vblnk_in  = 1'b0;
      hblnk_in  = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = '0; xpos = '0; ypos = '0; mouse_left = 1'b0; cursor_en = 1'b0;

      // Reset with toggling inputs, including a vblank edge that must not latch.
      for (int i = 0; i < 3; i++) begin
         hcount_in = 11'(i * 7 + 1);
         vcount_in = 11'(i * 3 + 2);
         hsync_in  = ~hsync_in;
         vsync_in  = ~vsync_in;
         hblnk_in  = ~hblnk_in;
         vblnk_in  = ~vblnk_in;
         rgb_in    = 12'hA5A ^ 12'(i);
         cursor_en = 1'b1;
         tick();
      end
      check("rst hcount", 32'(hcount_out), 32'd0);
      check("rst vcount", 32'(vcount_out), 32'd0);
      check("rst hsync", 32'(hsync_out), 32'd0);
      check("rst vsync", 32'(vsync_out), 32'd0);
      check("rst hblnk", 32'(hblnk_out), 32'd0);
      check("rst vblnk", 32'(vblnk_out), 32'd0);
      check("rst rgb", 32'(rgb_out), 32'd0);

      rst = 1'b0;
      hcount_in = '0; vcount_in = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = '0; cursor_en = 1'b0;
      tick();
      tick();

      // hsync pulse appears exactly two edges later.
      hsync_in = 1'b1;
      tick();
      check("hsync lat1", 32'(hsync_out), 32'd0);
      hsync_in = 1'b0;
      tick();
      check("hsync lat2", 32'(hsync_out), 32'd1);
      tick();
      check("hsync lat3", 32'(hsync_out), 32'd0);

      // Passthrough; enabling mid-frame has no effect until the next vblank edge.
      cursor_en = 1'b1;
      xpos = 12'd100;
      ypos = 12'd100;
      pixel(11'd100, 11'd100, 12'h123, 1'b0, 1'b0, "pass midframe", 12'h123);
      latch(12'd100, 12'd100, 1'b1);
      pixel(11'd100, 11'd100, 12'h123, 1'b0, 1'b0, "pass latched", 12'h000);

      // Sprite placement at (200,150).
      latch(12'd200, 12'd150, 1'b1);
      pixel(11'd200, 11'd150, 12'hABC, 1'b0, 1'b0, "tip", 12'h000);
      pixel(11'd216, 11'd150, 12'hABC, 1'b0, 1'b0, "right of", 12'hABC);
      pixel(11'd199, 11'd150, 12'hABC, 1'b0, 1'b0, "left of", 12'hABC);
      pixel(11'd215, 11'd150, 12'hABC, 1'b0, 1'b0, "row0 transp", 12'hABC);
      pixel(11'd202, 11'd155, 12'hABC, 1'b0, 1'b0, "fill", 12'hFFF);
      pixel(11'd205, 11'd155, 12'hABC, 1'b0, 1'b0, "diag edge", 12'h000);
      pixel(11'd200, 11'd166, 12'hABC, 1'b0, 1'b0, "below", 12'hABC);
      mouse_left = 1'b1;
      pixel(11'd202, 11'd155, 12'hABC, 1'b0, 1'b0, "fill pressed", 12'hF80);
      mouse_left = 1'b0;
      pixel(11'd200, 11'd150, 12'hABC, 1'b1, 1'b0, "tip hblank", 12'h000);
      pixel(11'd202, 11'd155, 12'hABC, 1'b1, 1'b0, "fill hblank", 12'h000);

      // Position change mid-frame only lands at the next vblank.
      xpos = 12'd400;
      pixel(11'd200, 11'd150, 12'h321, 1'b0, 1'b0, "old pos", 12'h000);
      pixel(11'd400, 11'd150, 12'h321, 1'b0, 1'b0, "new pos early", 12'h321);
      latch(12'd400, 12'd150, 1'b1);
      pixel(11'd400, 11'd150, 12'h321, 1'b0, 1'b0, "new pos", 12'h000);
      pixel(11'd200, 11'd150, 12'h321, 1'b0, 1'b0, "old pos gone", 12'h321);

      // Clamp to (799,599); everything past it is blanked, no wrap to 0.
      latch(12'd1000, 12'd700, 1'b1);
      pixel(11'd799, 11'd599, 12'h555, 1'b0, 1'b0, "clamp tip", 12'h000);
      pixel(11'd798, 11'd599, 12'h555, 1'b0, 1'b0, "clamp left", 12'h555);
      pixel(11'd800, 11'd599, 12'h555, 1'b1, 1'b0, "clip hblank", 12'h000);
      pixel(11'd799, 11'd600, 12'h555, 1'b0, 1'b1, "clip vblank", 12'h000);
      pixel(11'd0, 11'd0, 12'h555, 1'b0, 1'b0, "no wrap 0,0", 12'h555);
      pixel(11'd0, 11'd599, 12'h555, 1'b0, 1'b0, "no wrap col0", 12'h555);

      // Reset mid-frame drops the sprite until a fresh enabled latch.
      latch(12'd200, 12'd150, 1'b1);
      pixel(11'd200, 11'd150, 12'h777, 1'b0, 1'b0, "pre rst", 12'h000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pixel(11'd200, 11'd150, 12'h777, 1'b0, 1'b0, "post rst", 12'h777);
      latch(12'd200, 12'd150, 1'b0);
      pixel(11'd200, 11'd150, 12'h777, 1'b0, 1'b0, "latch en0", 12'h777);
      latch(12'd200, 12'd150, 1'b1);
      pixel(11'd200, 11'd150, 12'h777, 1'b0, 1'b0, "latch en1", 12'h000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
